iq_scale_block_ctrl: RTL and testbench

Sequencing controller for the block IQ scaler datapath.
- Aligns incoming IQ words to K28.7 (0xFC) commas.
- Assigns ping-pong sample buffers and tracks each block's peak |I|/|Q|.
- Shares one sequential divider to produce the 12-bit scaling factor per block.
- Drains completed blocks in order to the multiplier stage.
- Sits between the deserializer output and the scaler buffers, multipliers and divider.

---
 rtl/iq_scale_block_ctrl_if.sv | 38 +++
 rtl/iq_scale_block_ctrl.sv | 242 ++++++++++++++++++++++++
 tb/tb_iq_scale_block_ctrl.sv | 243 ++++++++++++++++++++++++
 3 files changed

// File: rtl/iq_scale_block_ctrl_if.sv
// Signal bundle between the IQ block scaler controller and its deserializer,
// buffer RAMs, divider and multiplier stage.
interface iq_scale_block_ctrl_if #(
    parameter int ADDR_W = 10,
    parameter int SF_W   = 12
);
    logic              in_valid;
    logic [31:0]       in_data;
    logic              wr_en;
    logic              wr_buf;
    logic [ADDR_W-1:0] wr_addr;
    logic              div_start;
    logic [15:0]       div_denom;
    logic              div_done;
    logic [15:0]       div_quotient;
    logic              out_ready;
    logic              rd_en;
    logic              rd_buf;
    logic [ADDR_W-1:0] rd_addr;
    logic              out_valid;
    logic              out_comma;
    logic [SF_W-1:0]   scaling_factor;
    logic              overrun;
    logic [15:0]       block_cnt;
    logic [15:0]       drop_cnt;

    modport master (
        input  in_valid, in_data, div_done, div_quotient, out_ready,
        output wr_en, wr_buf, wr_addr, div_start, div_denom, rd_en, rd_buf, rd_addr,
               out_valid, out_comma, scaling_factor, overrun, block_cnt, drop_cnt
    );

    modport slave (
        output in_valid, in_data, div_done, div_quotient, out_ready,
        input  wr_en, wr_buf, wr_addr, div_start, div_denom, rd_en, rd_buf, rd_addr,
               out_valid, out_comma, scaling_factor, overrun, block_cnt, drop_cnt
    );
endinterface

// File: rtl/iq_scale_block_ctrl.sv
// Block IQ scaler sequencer: comma-aligned capture into ping-pong buffers, shared
// divider arbitration and in-order drain. Define IQ_SCALE_CTRL_STATS_EN for block/drop counters.
module iq_scale_block_ctrl #(
    parameter int BLOCK_SIZE      = 1024,
    parameter int ADDR_W          = 10,
    parameter int SF_W            = 12,
    parameter int MAX_QUANT_VALUE = 32767
) (
    input  logic                 clk,
    input  logic                 rst,
    iq_scale_block_ctrl_if.master bus
);
    localparam logic [ADDR_W-1:0] LAST    = ADDR_W'(BLOCK_SIZE - 1);
    localparam logic [14:0]       MAG_MAX = 15'(MAX_QUANT_VALUE);
    localparam logic [SF_W-1:0]   SF_MAX  = '1;

    typedef enum logic [1:0] {HUNT, FILL, NEXT} cap_t;
    typedef enum logic [2:0] {B_FREE, B_FILLING, B_PEND, B_DIV, B_READY, B_DRAIN} buf_t;

    cap_t              cap_st, cap_nxt;
    buf_t              bst [2];
    logic [14:0]       peak [2];
    logic [SF_W-1:0]   factor [2];
    logic              cstart [2];
    logic              old;
    logic              cap_buf, cap_comma;
    logic [ADDR_W-1:0] idx;
    logic [14:0]       run_peak, peak_upd;
    logic              drain_act, drain_comma, rd_buf;
    logic [ADDR_W-1:0] rd_addr;
    logic [SF_W-1:0]   sf;
    logic              out_valid, out_comma;
    logic              div_start;
    logic [15:0]       div_denom;

    function automatic logic [14:0] mag(input logic [15:0] x);
        logic [15:0] n;
        n = x[15] ? (~x + 16'd1) : x;
        return n[15] ? MAG_MAX : n[14:0];
    endfunction

    logic        is_comma;
    logic [14:0] mag_i, mag_q, samp_mag;
    always_comb begin
        is_comma = bus.in_valid && ((bus.in_data[7:0] == 8'hFC) || (bus.in_data[15:8] == 8'hFC) ||
                                    (bus.in_data[23:16] == 8'hFC) || (bus.in_data[31:24] == 8'hFC));
        mag_i    = mag(bus.in_data[15:0]);
        mag_q    = mag(bus.in_data[31:16]);
        samp_mag = (mag_i > mag_q) ? mag_i : mag_q;
        peak_upd = (samp_mag > run_peak) ? samp_mag : run_peak;
    end

    // ---------------- capture FSM ----------------
    logic              start, start_buf, start_comma, adv, done, ovf;
    logic              wr_en, wr_buf;
    logic [ADDR_W-1:0] wr_addr;

    always_ff @(posedge clk) begin
        if (rst) cap_st <= HUNT;
        else     cap_st <= cap_nxt;
    end

    always_comb begin
        cap_nxt     = cap_st;
        start       = 1'b0;
        start_buf   = cap_buf;
        start_comma = 1'b0;
        adv         = 1'b0;
        done        = 1'b0;
        ovf         = 1'b0;
        unique case (cap_st)
            HUNT: if (is_comma && (bst[0] == B_FREE || bst[1] == B_FREE)) begin
                start       = 1'b1;
                start_buf   = (bst[0] == B_FREE) ? 1'b0 : 1'b1;
                start_comma = 1'b1;
                cap_nxt     = FILL;
            end
            NEXT: if (bus.in_valid) begin
                if (bst[~cap_buf] == B_FREE) begin
                    start       = 1'b1;
                    start_buf   = ~cap_buf;
                    start_comma = is_comma;
                    cap_nxt     = FILL;
                end else begin
                    ovf     = 1'b1;
                    cap_nxt = HUNT;
                end
            end
            FILL: if (is_comma) begin
                // mid-block comma restarts the block in place
                start       = 1'b1;
                start_comma = 1'b1;
            end else if (bus.in_valid) begin
                adv = 1'b1;
                if (idx == LAST) begin
                    done    = 1'b1;
                    cap_nxt = NEXT;
                end
            end
            default: cap_nxt = HUNT;
        endcase
        wr_en   = start | adv;
        wr_buf  = start ? start_buf : cap_buf;
        wr_addr = start ? '0 : idx;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cap_buf   <= 1'b0;
            cap_comma <= 1'b0;
            idx       <= '0;
            run_peak  <= '0;
        end else if (start) begin
            cap_buf   <= start_buf;
            cap_comma <= start_comma;
            idx       <= ADDR_W'(1);
            run_peak  <= start_comma ? '0 : samp_mag;
        end else if (adv) begin
            idx      <= idx + 1'b1;
            run_peak <= peak_upd;
        end
    end

    // ---------------- buffer arbitration ----------------
    // 'old' names the buffer whose block completed first, keeping divide and drain in order.
    logic [1:0] post, div_cand, drain_cand;
    logic       div_go, div_sel, drain_go, drain_sel, rd_en, drain_end;
    always_comb begin
        post[0]       = bst[0] inside {B_PEND, B_DIV, B_READY, B_DRAIN};
        post[1]       = bst[1] inside {B_PEND, B_DIV, B_READY, B_DRAIN};
        div_cand[0]   = bst[0] == B_PEND && peak[0] != '0 && !(bst[1] == B_PEND && old != 1'b0);
        div_cand[1]   = bst[1] == B_PEND && peak[1] != '0 && !(bst[0] == B_PEND && old != 1'b1);
        drain_cand[0] = bst[0] == B_READY && !(post[1] && old != 1'b0);
        drain_cand[1] = bst[1] == B_READY && !(post[0] && old != 1'b1);
        div_go        = bst[0] != B_DIV && bst[1] != B_DIV && (|div_cand);
        div_sel       = !div_cand[0];
        drain_go      = !drain_act && (|drain_cand);
        drain_sel     = !drain_cand[0];
        rd_en         = drain_act && bus.out_ready;
        drain_end     = rd_en && rd_addr == LAST;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            old       <= 1'b0;
            div_start <= 1'b0;
            div_denom <= '0;
            for (int b = 0; b < 2; b++) begin
                bst[b]    <= B_FREE;
                peak[b]   <= '0;
                factor[b] <= '0;
                cstart[b] <= 1'b0;
            end
        end else begin
            div_start <= div_go;
            if (div_go) div_denom <= {1'b0, peak[div_sel]};
            if (done)   old <= post[~cap_buf] ? ~cap_buf : cap_buf;
            for (int b = 0; b < 2; b++) begin
                case (bst[b])
                    B_FREE:    if (start && start_buf == 1'(b)) bst[b] <= B_FILLING;
                    B_FILLING: if (done && cap_buf == 1'(b)) begin
                        bst[b]    <= B_PEND;
                        peak[b]   <= peak_upd;
                        cstart[b] <= cap_comma;
                    end
                    B_PEND: if (peak[b] == '0) begin
                        bst[b]    <= B_READY;
                        factor[b] <= SF_MAX;
                    end else if (div_go && div_sel == 1'(b)) begin
                        bst[b] <= B_DIV;
                    end
                    B_DIV: if (bus.div_done) begin
                        bst[b]    <= B_READY;
                        factor[b] <= (bus.div_quotient > 16'(SF_MAX)) ? SF_MAX : bus.div_quotient[SF_W-1:0];
                    end
                    B_READY:   if (drain_go && drain_sel == 1'(b)) bst[b] <= B_DRAIN;
                    B_DRAIN:   if (drain_end) bst[b] <= B_FREE;
                    default:   bst[b] <= B_FREE;
                endcase
            end
        end
    end

    // ---------------- drain ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            drain_act   <= 1'b0;
            drain_comma <= 1'b0;
            rd_buf      <= 1'b0;
            rd_addr     <= '0;
            sf          <= '0;
            out_valid   <= 1'b0;
            out_comma   <= 1'b0;
        end else begin
            out_valid <= rd_en;
            out_comma <= rd_en && rd_addr == '0 && drain_comma;
            if (drain_go) begin
                drain_act   <= 1'b1;
                drain_comma <= cstart[drain_sel];
                rd_buf      <= drain_sel;
                rd_addr     <= '0;
                sf          <= factor[drain_sel];
            end else if (rd_en) begin
                rd_addr <= rd_addr + 1'b1;
                if (drain_end) drain_act <= 1'b0;
            end
        end
    end

    assign bus.wr_en          = wr_en;
    assign bus.wr_buf         = wr_buf;
    assign bus.wr_addr        = wr_addr;
    assign bus.div_start      = div_start;
    assign bus.div_denom      = div_denom;
    assign bus.rd_en          = rd_en;
    assign bus.rd_buf         = rd_buf;
    assign bus.rd_addr        = rd_addr;
    assign bus.out_valid      = out_valid;
    assign bus.out_comma      = out_comma;
    assign bus.scaling_factor = sf;
    assign bus.overrun        = ovf;

`ifdef IQ_SCALE_CTRL_STATS_EN
    logic [15:0] blk_q, drop_q;
    logic        abort_evt;
    assign abort_evt = (cap_st == FILL) && is_comma;
    always_ff @(posedge clk) begin
        if (rst) begin
            blk_q  <= '0;
            drop_q <= '0;
        end else begin
            if (drain_end && blk_q != 16'hFFFF)             blk_q  <= blk_q + 16'd1;
            if ((ovf || abort_evt) && drop_q != 16'hFFFF)  drop_q <= drop_q + 16'd1;
        end
    end
    assign bus.block_cnt = blk_q;
    assign bus.drop_cnt  = drop_q;
`else
    assign bus.block_cnt = '0;
    assign bus.drop_cnt  = '0;
`endif
endmodule

// File: tb/tb_iq_scale_block_ctrl.sv
// Directed bench for iq_scale_block_ctrl: divider model answers each div_start after
// a few cycles with a per-test quotient; a monitor tracks drain ordering and alignment.
module tb_iq_scale_block_ctrl;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    iq_scale_block_ctrl_if bus ();
    iq_scale_block_ctrl dut (.clk(clk), .rst(rst), .bus(bus));

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    // divider model
    logic [15:0] q_resp = '0;
    logic [15:0] last_denom = '0;
    int          n_div = 0;
    initial begin
        int cnt;
        cnt = 0;
        bus.div_done     = 1'b0;
        bus.div_quotient = '0;
        forever begin
            @(posedge clk); #1;
            bus.div_done = 1'b0;
            if (bus.div_start) begin
                n_div++;
                last_denom = bus.div_denom;
                cnt = 4;
            end else if (cnt > 0) begin
                cnt--;
                if (cnt == 0) begin
                    bus.div_done     = 1'b1;
                    bus.div_quotient = q_resp;
                end
            end
        end
    end

    // out_ready driver: 0 = hold low, 1 = hold high, 2 = toggle
    int rdy_mode = 1;
    initial begin
        bus.out_ready = 1'b1;
        forever begin
            @(posedge clk); #1;
            if (rdy_mode == 0)      bus.out_ready = 1'b0;
            else if (rdy_mode == 1) bus.out_ready = 1'b1;
            else                    bus.out_ready = ~bus.out_ready;
        end
    end

    // drain monitor
    int out_cnt = 0, rd_seq = 0, ord_err = 0, gate_err = 0, align_err = 0, comma_err = 0, ovr_cyc = 0;
    initial begin
        logic prev_rd;
        prev_rd = 1'b0;
        forever begin
            @(negedge clk);
            if (bus.out_valid !== prev_rd) align_err++;
            prev_rd = bus.rd_en;
            if (bus.rd_en) begin
                if (bus.out_ready !== 1'b1) gate_err++;
                if (bus.rd_addr !== 10'(rd_seq)) ord_err++;
                rd_seq = (rd_seq + 1) % 1024;
            end
            if (bus.out_valid) begin
                if (bus.out_comma !== (out_cnt % 1024 == 0)) comma_err++;
                out_cnt++;
            end else if (bus.out_comma) begin
                comma_err++;
            end
            if (bus.overrun) ovr_cyc++;
        end
    end

    // n samples; sample 0 is a comma word if c0; I peak at index 100, Q peak at 200
    task automatic send(input bit c0, input int n, input logic [15:0] pi, input logic [15:0] pq,
                        input bit exp_wr, output int bad);
        bad = 0;
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
            bus.in_valid = 1'b1;
            if (i == 0 && c0)  bus.in_data = 32'h0000_00FC;
            else if (i == 100) bus.in_data = {16'h0, pi};
            else if (i == 200) bus.in_data = {pq, 16'h0};
            else               bus.in_data = '0;
            @(negedge clk);
            if (exp_wr) begin
                if (bus.wr_en !== 1'b1 || bus.wr_addr !== 10'(i)) bad++;
            end else if (bus.wr_en !== 1'b0) begin
                bad++;
            end
        end
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        bus.in_data  = '0;
    endtask

    task automatic wait_out(input int target);
        int k;
        k = 0;
        while (out_cnt < target && k < 20000) begin
            @(negedge clk);
            k++;
        end
        chk("drain_done", 32'(out_cnt >= target), 1);
        repeat (2) @(negedge clk);
    endtask

    task automatic full(input string tag, input logic [15:0] pi, input logic [15:0] pq,
                        input logic [15:0] q, input bit exp_div, input logic [15:0] exp_den,
                        input logic [11:0] exp_sf);
        int nd0, base, bad;
        nd0    = n_div;
        base   = out_cnt;
        q_resp = q;
        send(1'b1, 1024, pi, pq, 1'b1, bad);
        chk({tag, "_wr"}, bad, 0);
        wait_out(base + 1024);
        chk({tag, "_ndiv"}, n_div - nd0, exp_div ? 1 : 0);
        if (exp_div) chk({tag, "_denom"}, last_denom, exp_den);
        chk({tag, "_sf"}, bus.scaling_factor, exp_sf);
    endtask

    initial begin
        int bad, base, nd0, ov0, k;
        bus.in_valid = 1'b0;
        bus.in_data  = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_wr_en", bus.wr_en, 0);
        chk("rst_rd_en", bus.rd_en, 0);
        chk("rst_div_start", bus.div_start, 0);
        chk("rst_out_valid", bus.out_valid, 0);
        chk("rst_sf", bus.scaling_factor, 0);
        chk("rst_overrun", bus.overrun, 0);
        chk("rst_blk", bus.block_cnt, 0);
        chk("rst_drop", bus.drop_cnt, 0);

        send(1'b0, 3, 16'h0, 16'h0, 1'b0, bad);
        chk("hunt_ignore", bad, 0);

        full("pk4000", 16'h4000, 16'h0000, 16'd1,    1'b1, 16'd16384, 12'd1);
        full("pk8",    16'h0008, 16'h0000, 16'd4095, 1'b1, 16'd8,     12'd4095);
        full("clamp",  16'hFFFB, 16'h0000, 16'd9000, 1'b1, 16'd5,     12'd4095);
        full("q8000",  16'h0000, 16'h8000, 16'd1,    1'b1, 16'd32767, 12'd1);
        full("zero",   16'h0000, 16'h0000, 16'd7,    1'b0, 16'd0,     12'd4095);

        // mid-block comma at index 500
        nd0 = n_div;
        base = out_cnt;
        send(1'b1, 500, 16'h7000, 16'h0, 1'b1, bad);
        chk("abort_pre_wr", bad, 0);
        q_resp = 16'd3;
        send(1'b1, 1024, 16'h0100, 16'h0, 1'b1, bad);
        chk("abort_wr", bad, 0);
        wait_out(base + 1024);
        chk("abort_ndiv", n_div - nd0, 1);
        chk("abort_denom", last_denom, 16'd256);
        chk("abort_sf", bus.scaling_factor, 3);
`ifdef IQ_SCALE_CTRL_STATS_EN
        chk("abort_drop", bus.drop_cnt, 1);
`else
        chk("abort_drop", bus.drop_cnt, 0);
`endif

        // stall output across three block starts
        rdy_mode = 0;
        q_resp = 16'd2;
        base = out_cnt;
        ov0 = ovr_cyc;
        send(1'b1, 1024, 16'h0010, 16'h0, 1'b1, bad);
        chk("ovf_a_wr", bad, 0);
        send(1'b1, 1024, 16'h0020, 16'h0, 1'b1, bad);
        chk("ovf_b_wr", bad, 0);
        repeat (20) @(negedge clk);
        send(1'b1, 1, 16'h0, 16'h0, 1'b0, bad);
        chk("ovf_c_discard", bad, 0);
        chk("ovf_pulse", ovr_cyc - ov0, 1);
        send(1'b1, 1, 16'h0, 16'h0, 1'b0, bad);
        chk("ovf_hunt_nofree", bad, 0);
        rdy_mode = 2;
        wait_out(base + 1024);
        send(1'b0, 1, 16'h0, 16'h0, 1'b0, bad);
        chk("ovf_hunt_nocomma", bad, 0);
        send(1'b1, 1024, 16'h0030, 16'h0, 1'b1, bad);
        chk("ovf_d_wr", bad, 0);
        wait_out(base + 3072);
        chk("ovf_sf", bus.scaling_factor, 2);
        chk("ovf_pulse_total", ovr_cyc - ov0, 1);
        chk("rd_gate", gate_err, 0);
        chk("rd_order", ord_err, 0);
        chk("out_align", align_err, 0);
        chk("out_comma", comma_err, 0);
        chk("out_total", out_cnt, 9 * 1024);
`ifdef IQ_SCALE_CTRL_STATS_EN
        chk("blk_cnt", bus.block_cnt, 9);
        chk("drop_cnt", bus.drop_cnt, 2);
`else
        chk("blk_cnt", bus.block_cnt, 0);
        chk("drop_cnt", bus.drop_cnt, 0);
`endif

        // reset while a division is in flight
        rdy_mode = 1;
        nd0 = n_div;
        q_resp = 16'd1;
        send(1'b1, 1024, 16'h0040, 16'h0, 1'b1, bad);
        k = 0;
        while (n_div == nd0 && k < 50) begin
            @(posedge clk); #1;
            k++;
        end
        chk("rst_div_seen", 32'(n_div > nd0), 1);
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        base = out_cnt;
        repeat (30) @(negedge clk);
        chk("rst_no_drain", out_cnt, base);
        chk("rst_sf_clear", bus.scaling_factor, 0);
        chk("rst_blk_clear", bus.block_cnt, 0);
        chk("rst_wr_idle", bus.wr_en, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #800000;
        $display("FAIL watchdog expired checks %0d errors %0d", checks, errors);
        $fatal(1);
    end
endmodule
